// File: rtl/buff2mac_pkg.sv
// buff2mac_pkg: shared definitions for the buffer-to-MAC transmit engine.
//   - FSM state encoding
//   - header length field bounds
//   - last-QW byte-valid mask and QW-count helpers
`timescale 1ns/1ps
package buff2mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_START  = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    localparam int unsigned LEN_MSB = 15;
    localparam int unsigned LEN_LSB = 0;
    localparam int unsigned LEN_W   = LEN_MSB - LEN_LSB + 1;
    localparam int unsigned LEN_W1  = LEN_W + 1;
    // ceil(65535/8) = 8192 needs 14 bits
    localparam int unsigned QWC_W   = LEN_W - 2;

    // Byte-valid mask for the last QW of a frame, from L[2:0]
    function automatic logic [7:0] last_mask(input logic [2:0] lo);
        if (lo == 3'd0) begin
            return 8'hFF;
        end
        return 8'hFF >> (4'd8 - {1'b0, lo});
    endfunction

    // Number of data QWs following a header: ceil(L/8)
    function automatic logic [QWC_W-1:0] qw_count(input logic [LEN_W-1:0] len);
        logic [LEN_W1-1:0] sum;
        sum = {1'b0, len} + LEN_W1'(7);
        return QWC_W'(sum >> 3);
    endfunction

endpackage

// File: rtl/buff2mac.sv
// buff2mac: reads length-prefixed packets from a circular QW buffer and
// streams them to the MAC transmit interface.
//
// Ports:
//   clk, rst        MAC tx clock, async active-high reset
//   committed_prod  producer pointer [BW:0] (bit BW is the wrap bit)
//   rd_addr         buffer read address; rd_data returns 1 cycle later
//   rd_data         registered buffer read data
//   committed_cons  consumer pointer returned to the producer
//   tx_data         MAC tx data (byte 0 = bits [7:0])
//   tx_data_valid   per-byte valid, contiguous from LSB
//   tx_start        first QW of a frame is on tx_data (held until tx_ack)
//   tx_ack          MAC accepted the first QW; rest follow back-to-back
//   activity        frame in progress
//
// Optional feature: define BUFF2MAC_STATS_EN to add tx_frames (completed
// frames) and zero_len_cnt (L==0 headers skipped).
`timescale 1ns/1ps
module buff2mac
    import buff2mac_pkg::*;
#(
    parameter int unsigned BW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [BW:0]   committed_prod,
    output logic [BW:0]   rd_addr,
    input  logic [63:0]   rd_data,
    output logic [BW:0]   committed_cons,
    output logic [63:0]   tx_data,
    output logic [7:0]    tx_data_valid,
    output logic          tx_start,
    input  logic          tx_ack,
    output logic          activity
`ifdef BUFF2MAC_STATS_EN
    ,
    output logic [31:0]   tx_frames,
    output logic [15:0]   zero_len_cnt
`endif
);

    localparam int unsigned PW = BW + 1;

    state_t           state;
    logic             fill_cycle;   // second HDR cycle: first data QW arriving
    logic [QWC_W-1:0] nqw;          // data QWs in the current frame
    logic [QWC_W-1:0] rem;          // QWs still to present after tx_data
    logic [7:0]       last_vm;      // byte-valid mask of the last QW
    logic [63:0]      hold_q;       // second QW parked while START waits
    logic             hold_vld;

    logic [LEN_W-1:0] hdr_len;
    logic [PW-1:0]    done_ptr;
    logic             frame_done;
    logic             advance;

    assign hdr_len  = rd_data[LEN_MSB:LEN_LSB];
    assign done_ptr = committed_cons + PW'(1) + PW'(nqw);

    // Last QW is on tx_data this cycle (and accepted, if still in START)
    assign frame_done = ((state == ST_START) && tx_ack && (rem == '0)) ||
                        ((state == ST_STREAM) && (rem == '0));
    assign advance    = ((state == ST_START) && tx_ack && (rem != '0)) ||
                        ((state == ST_STREAM) && (rem != '0));

    // Read pipeline: rd_addr runs two QWs ahead of tx_data. While START
    // stalls, the memory keeps returning QW3 and QW2 is parked in hold_q,
    // so streaming after tx_ack proceeds without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            fill_cycle     <= 1'b0;
            nqw            <= '0;
            rem            <= '0;
            last_vm        <= '0;
            hold_q         <= '0;
            hold_vld       <= 1'b0;
            rd_addr        <= '0;
            committed_cons <= '0;
            tx_data        <= '0;
            tx_data_valid  <= '0;
            tx_start       <= 1'b0;
            activity       <= 1'b0;
`ifdef BUFF2MAC_STATS_EN
            tx_frames      <= '0;
            zero_len_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // rd_addr == committed_cons here, so the header arrives in HDR
                    if (committed_prod != committed_cons) begin
                        state      <= ST_HDR;
                        fill_cycle <= 1'b0;
                        rd_addr    <= committed_cons + PW'(1);
                        activity   <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (!fill_cycle) begin
                        if (hdr_len == '0) begin
                            // Empty packet: skip the header, rd_addr already points past it
                            committed_cons <= committed_cons + PW'(1);
                            activity       <= 1'b0;
                            state          <= ST_IDLE;
`ifdef BUFF2MAC_STATS_EN
                            zero_len_cnt   <= zero_len_cnt + 16'd1;
`endif
                        end else begin
                            nqw        <= qw_count(hdr_len);
                            last_vm    <= last_mask(hdr_len[2:0]);
                            rd_addr    <= rd_addr + PW'(1);
                            fill_cycle <= 1'b1;
                        end
                    end else begin
                        tx_data       <= rd_data;
                        rd_addr       <= rd_addr + PW'(1);
                        rem           <= nqw - QWC_W'(1);
                        tx_data_valid <= (nqw == QWC_W'(1)) ? last_vm : 8'hFF;
                        tx_start      <= 1'b1;
                        hold_vld      <= 1'b0;
                        fill_cycle    <= 1'b0;
                        state         <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_ack) begin
                        tx_start <= 1'b0;
                        if (rem != '0) begin
                            tx_data <= hold_vld ? hold_q : rd_data;
                            state   <= ST_STREAM;
                        end
                    end else if (!hold_vld) begin
                        hold_q   <= rd_data;
                        hold_vld <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (rem != '0) begin
                        tx_data <= rd_data;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Shared per-QW advance for START (after ack) and STREAM
            if (advance) begin
                rd_addr       <= rd_addr + PW'(1);
                rem           <= rem - QWC_W'(1);
                tx_data_valid <= (rem == QWC_W'(1)) ? last_vm : 8'hFF;
            end

            // Retire the packet on the cycle its last QW is presented
            if (frame_done) begin
                committed_cons <= done_ptr;
                rd_addr        <= done_ptr;
                tx_data_valid  <= '0;
                tx_start       <= 1'b0;
                activity       <= 1'b0;
                state          <= ST_IDLE;
`ifdef BUFF2MAC_STATS_EN
                tx_frames      <= tx_frames + 32'd1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_buff2mac.sv
// tb_buff2mac: directed bench for buff2mac (BW=4) with a registered-read
// buffer model. Stats ports are connected when BUFF2MAC_STATS_EN is defined.
`timescale 1ns/1ps
module tb_buff2mac;

    localparam int unsigned BW    = 4;
    localparam int unsigned PW    = BW + 1;
    localparam int unsigned DEPTH = 1 << BW;

    logic          clk;
    logic          rst;
    logic [PW-1:0] committed_prod;
    logic [PW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [PW-1:0] committed_cons;
    logic [63:0]   tx_data;
    logic [7:0]    tx_data_valid;
    logic          tx_start;
    logic          tx_ack;
    logic          activity;
`ifdef BUFF2MAC_STATS_EN
    logic [31:0]   tx_frames;
    logic [15:0]   zero_len_cnt;
`endif

    logic [63:0] mem [DEPTH];

    int errors = 0;
    int checks = 0;

    buff2mac #(.BW(BW)) dut (
        .clk            (clk),
        .rst            (rst),
        .committed_prod (committed_prod),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .committed_cons (committed_cons),
        .tx_data        (tx_data),
        .tx_data_valid  (tx_data_valid),
        .tx_start       (tx_start),
        .tx_ack         (tx_ack),
        .activity       (activity)
`ifdef BUFF2MAC_STATS_EN
        ,
        .tx_frames      (tx_frames),
        .zero_len_cnt   (zero_len_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer model: registered read, data valid one cycle after the address
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr[BW-1:0]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int fid, input int q);
        return {32'hCAFE0000 | 32'(fid), 32'(q)};
    endfunction

    task automatic write_frame(input logic [PW-1:0] p, input int len, input int nqw, input int fid);
        logic [PW-1:0] a;
        mem[p[BW-1:0]] = {48'hDEAD_BEEF_0000, 16'(len)};
        for (int q = 1; q <= nqw; q++) begin
            a = p + PW'(q);
            mem[a[BW-1:0]] = pat(fid, q);
        end
    endtask

    // Receive one frame: hold = cycles tx_start stays high before tx_ack
    task automatic recv_frame(input string name, input int fid, input int nqw,
                              input logic [7:0] lastm, input int hold,
                              input logic [PW-1:0] exp_cons);
        int t;
        int reps;
        logic [7:0] ev;
        t = 0;
        while (tx_start !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_start_seen"}, 64'(tx_start), 64'd1);
        if (tx_start !== 1'b1) return;
        for (int q = 1; q <= nqw; q++) begin
            ev   = (q == nqw) ? lastm : 8'hFF;
            reps = (q == 1) ? hold : 1;
            for (int c = 1; c <= reps; c++) begin
                check($sformatf("%s_q%0d_data", name, q), tx_data, pat(fid, q));
                check($sformatf("%s_q%0d_valid", name, q), 64'(tx_data_valid), 64'(ev));
                check($sformatf("%s_q%0d_start", name, q), 64'(tx_start), (q == 1) ? 64'd1 : 64'd0);
                check($sformatf("%s_q%0d_act", name, q), 64'(activity), 64'd1);
                if (q == 1 && c == reps) tx_ack = 1'b1;
                @(negedge clk);
                tx_ack = 1'b0;
            end
        end
        check({name, "_end_valid"}, 64'(tx_data_valid), 64'd0);
        check({name, "_end_start"}, 64'(tx_start), 64'd0);
        check({name, "_end_act"}, 64'(activity), 64'd0);
        check({name, "_cons"}, 64'(committed_cons), 64'(exp_cons));
        check({name, "_rd_addr"}, 64'(rd_addr), 64'(exp_cons));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        logic saw;
        rst            = 1'b0;
        tx_ack         = 1'b0;
        committed_prod = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
        #1 rst = 1'b1;
        #2;
        check("rst_valid", 64'(tx_data_valid), 64'd0);
        check("rst_start", 64'(tx_start), 64'd0);
        check("rst_act", 64'(activity), 64'd0);
        check("rst_cons", 64'(committed_cons), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_data", tx_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Empty buffer: nothing happens for 100 cycles
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_start", 64'(tx_start), 64'd0);
            check("idle_valid", 64'(tx_data_valid), 64'd0);
            check("idle_rd_addr", 64'(rd_addr), 64'd0);
            check("idle_cons", 64'(committed_cons), 64'd0);
        end

        // L=60: 8 QWs, ack on the 5th START cycle, last mask 0x0F
        write_frame(5'd0, 60, 8, 1);
        committed_prod = 5'd9;
        recv_frame("l60", 1, 8, 8'h0F, 5, 5'd9);

        // L=8: single QW, full mask, cons advances by 2
        write_frame(5'd9, 8, 1, 2);
        committed_prod = 5'd11;
        recv_frame("l8", 2, 1, 8'hFF, 1, 5'd11);

        // L=0 header: skipped silently, cons advances by 1
        mem[11] = {48'h1234_5678_9ABC, 16'd0};
        committed_prod = 5'd12;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (tx_start !== 1'b0 || tx_data_valid !== 8'h00) saw = 1'b1;
        end
        check("zl_quiet", 64'(saw), 64'd0);
        check("zl_cons", 64'(committed_cons), 64'd12);

        // L=64 after the empty header; data wraps through the buffer end
        write_frame(5'd12, 64, 8, 3);
        committed_prod = 5'd21;
        recv_frame("l64", 3, 8, 8'hFF, 2, 5'd21);

        // L=61: mask 0x1F, brings cons to 0x1E
        write_frame(5'd21, 61, 8, 4);
        committed_prod = 5'd30;
        recv_frame("l61", 4, 8, 8'h1F, 3, 5'h1E);

        // Wrap: cons 0x1E, L=24 -> 0x02 with wrap bit cleared
        write_frame(5'h1E, 24, 3, 5);
        committed_prod = 5'h02;
        recv_frame("wrap", 5, 3, 8'hFF, 1, 5'h02);

`ifdef BUFF2MAC_STATS_EN
        check("stat_frames", 64'(tx_frames), 64'd5);
        check("stat_zero", 64'(zero_len_cnt), 64'd1);
`endif

        // Reset in the middle of STREAM
        write_frame(5'h02, 64, 8, 6);
        committed_prod = 5'd11;
        t = 0;
        while (tx_start !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("mid_start_seen", 64'(tx_start), 64'd1);
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
        check("mid_q2_data", tx_data, pat(6, 2));
        check("mid_q2_valid", 64'(tx_data_valid), 64'hFF);
        @(negedge clk);
        check("mid_q3_data", tx_data, pat(6, 3));
        #2 rst = 1'b1;
        committed_prod = '0;
        #1;
        check("mid_rst_valid", 64'(tx_data_valid), 64'd0);
        check("mid_rst_start", 64'(tx_start), 64'd0);
        check("mid_rst_act", 64'(activity), 64'd0);
        check("mid_rst_cons", 64'(committed_cons), 64'd0);
        check("mid_rst_rd_addr", 64'(rd_addr), 64'd0);
`ifdef BUFF2MAC_STATS_EN
        check("mid_rst_frames", 64'(tx_frames), 64'd0);
        check("mid_rst_zero", 64'(zero_len_cnt), 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle_valid", 64'(tx_data_valid), 64'd0);

        // Clean restart from address 0
        write_frame(5'd0, 8, 1, 7);
        committed_prod = 5'd2;
        recv_frame("post_rst", 7, 1, 8'hFF, 1, 5'd2);
`ifdef BUFF2MAC_STATS_EN
        check("post_rst_frames", 64'(tx_frames), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
